gpu_mem_cpuvram: RTL and testbench

//  CPU->VRAM rectangle upload. Counterpart of the VRAM->CPU read path.

---
 rtl/gpu_mem_cpuvram.sv | 146 ++++++++++++++
 tb/tb_gpu_mem_cpuvram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_cpuvram.sv
// CPU->VRAM rectangle upload: packs a row-major stream of pixel pairs into
// 16-pixel VRAM lines and issues masked 32-byte writes on the GPU command port.
module gpu_mem_cpuvram #(
   parameter int PIXEL_BURST = 16,
   parameter int X_BITS      = 10,
   parameter int Y_BITS      = 9
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_valid_i,
   input  logic [15:0]                 req_x_i,
   input  logic [15:0]                 req_y_i,
   input  logic [15:0]                 req_sizex_i,
   input  logic [15:0]                 req_sizey_i,
   output logic                        req_accept_o,
   input  logic                        data_valid_i,
   input  logic [31:0]                 data_pair_i,
   output logic                        data_accept_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        gpu_command_o,
   input  logic                        gpu_busy_i,
   output logic                        gpu_write_o,
   output logic [1:0]                  gpu_size_o,
   output logic [14:0]                 gpu_addr_o,
   output logic [2:0]                  gpu_sub_addr_o,
   output logic [PIXEL_BURST-1:0]      gpu_write_mask_o,
   output logic [PIXEL_BURST*16-1:0]   gpu_data_out_o
);

   localparam int LANE_BITS = $clog2(PIXEL_BURST);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FLUSH, ST_DONE} state_t;

   state_t                        state;
   logic [15:0]                   start_x, end_x, cur_x, cur_y;
   logic [31:0]                   recv_left, place_left;
   logic [1:0][15:0]              hold;
   logic [1:0]                    hold_cnt;
   logic                          last_q;
   logic [PIXEL_BURST-1:0]        mask;
   logic [PIXEL_BURST-1:0][15:0]  lanes;
   logic [14:0]                   line_addr;

   logic                          placing, data_take, row_end, last_pix, flush_now;
   logic [15:0]                   x_inc, next_x, next_y;
   logic [14:0]                   cur_line, next_line;
   logic [LANE_BITS-1:0]          lane;
   logic [31:0]                   req_total;

   // A pixel is placed every FILL cycle the hold register is non-empty; a new
   // pair is only taken once the hold register will be empty after this cycle.
   assign placing   = (state == ST_FILL) && (hold_cnt != 2'd0);
   assign data_take = (state == ST_FILL) && data_valid_i && (recv_left != 32'd0) &&
                      ((hold_cnt == 2'd0) || ((hold_cnt == 2'd1) && placing));

   assign x_inc     = cur_x + 16'd1;
   assign row_end   = (x_inc == end_x);
   assign next_x    = row_end ? start_x : x_inc;
   assign next_y    = row_end ? cur_y + 16'd1 : cur_y;
   assign cur_line  = {cur_y[Y_BITS-1:0], cur_x[X_BITS-1:LANE_BITS]};
   assign next_line = {next_y[Y_BITS-1:0], next_x[X_BITS-1:LANE_BITS]};
   assign lane      = cur_x[LANE_BITS-1:0];
   assign last_pix  = (place_left == 32'd1);
   assign flush_now = placing && (last_pix || (next_line != cur_line));
   assign req_total = 32'(req_sizex_i) * 32'(req_sizey_i);

   assign req_accept_o     = (state == ST_IDLE);
   assign busy_o           = (state != ST_IDLE);
   assign done_o           = (state == ST_DONE);
   assign gpu_command_o    = (state == ST_FLUSH);
   assign data_accept_o    = data_take;
   assign gpu_write_o      = 1'b1;
   assign gpu_size_o       = 2'd1;
   assign gpu_sub_addr_o   = 3'd0;
   assign gpu_addr_o       = line_addr;
   assign gpu_write_mask_o = mask;
   assign gpu_data_out_o   = lanes;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         start_x    <= '0;
         end_x      <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         recv_left  <= '0;
         place_left <= '0;
         hold       <= '0;
         hold_cnt   <= '0;
         last_q     <= 1'b0;
         mask       <= '0;
         lanes      <= '0;
         line_addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  start_x    <= req_x_i;
                  cur_x      <= req_x_i;
                  cur_y      <= req_y_i;
                  end_x      <= req_x_i + req_sizex_i;
                  recv_left  <= req_total;
                  place_left <= req_total;
                  hold_cnt   <= 2'd0;
                  last_q     <= 1'b0;
                  state      <= (req_total == 32'd0) ? ST_DONE : ST_FILL;
               end
            end
            ST_FILL: begin
               // With an odd pixel count the final pair only contributes its low pixel.
               if (data_take) begin
                  hold      <= data_pair_i;
                  hold_cnt  <= (recv_left == 32'd1) ? 2'd1 : 2'd2;
                  recv_left <= recv_left - ((recv_left == 32'd1) ? 32'd1 : 32'd2);
               end else if (placing) begin
                  hold[0]  <= hold[1];
                  hold_cnt <= hold_cnt - 2'd1;
               end
               if (placing) begin
                  lanes[lane] <= hold[0];
                  mask[lane]  <= 1'b1;
                  line_addr   <= cur_line;
                  cur_x       <= next_x;
                  cur_y       <= next_y;
                  place_left  <= place_left - 32'd1;
                  if (flush_now) begin
                     last_q <= last_pix;
                     state  <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               if (!gpu_busy_i) begin
                  mask  <= '0;
                  lanes <= '0;
                  state <= last_q ? ST_DONE : ST_FILL;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_mem_cpuvram.sv
// Randomized bench for gpu_mem_cpuvram: a pixel-level model groups each rectangle
// into expected line writes, which are compared against the accepted GPU commands.
module tb_gpu_mem_cpuvram;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         req_valid_i;
   logic [15:0]  req_x_i, req_y_i, req_sizex_i, req_sizey_i;
   logic         req_accept_o;
   logic         data_valid_i;
   logic [31:0]  data_pair_i;
   logic         data_accept_o;
   logic         busy_o, done_o;
   logic         gpu_command_o;
   logic         gpu_busy_i;
   logic         gpu_write_o;
   logic [1:0]   gpu_size_o;
   logic [14:0]  gpu_addr_o;
   logic [2:0]   gpu_sub_addr_o;
   logic [15:0]  gpu_write_mask_o;
   logic [255:0] gpu_data_out_o;

   gpu_mem_cpuvram dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_x_i(req_x_i), .req_y_i(req_y_i),
      .req_sizex_i(req_sizex_i), .req_sizey_i(req_sizey_i), .req_accept_o(req_accept_o),
      .data_valid_i(data_valid_i), .data_pair_i(data_pair_i), .data_accept_o(data_accept_o),
      .busy_o(busy_o), .done_o(done_o),
      .gpu_command_o(gpu_command_o), .gpu_busy_i(gpu_busy_i), .gpu_write_o(gpu_write_o),
      .gpu_size_o(gpu_size_o), .gpu_addr_o(gpu_addr_o), .gpu_sub_addr_o(gpu_sub_addr_o),
      .gpu_write_mask_o(gpu_write_mask_o), .gpu_data_out_o(gpu_data_out_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [14:0]  addr;
      logic [15:0]  mask;
      logic [255:0] data;
   } wr_t;

   wr_t          exp_q[$];
   logic [15:0]  pix   [0:1023];
   logic [31:0]  pairs [0:511];
   int           checks = 0;
   int           errors = 0;

   task automatic check_output(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h", tag, actual, expected);
      end
   endtask

   // Walk the rectangle pixel by pixel; consecutive pixels sharing a VRAM line form one write.
   task automatic build_model(input logic [15:0] x0, input logic [15:0] y0, input int sx, input int npix);
      logic [15:0] x, y;
      logic [14:0] a;
      wr_t         w;
      bit          open;
      open = 0;
      exp_q.delete();
      w.addr = '0; w.mask = '0; w.data = '0;
      for (int k = 0; k < npix; k++) begin
         x = x0 + 16'(k % sx);
         y = y0 + 16'(k / sx);
         a = {y[8:0], x[9:4]};
         if (open && a != w.addr) begin
            exp_q.push_back(w);
            open = 0;
         end
         if (!open) begin
            w.addr = a; w.mask = '0; w.data = '0; open = 1;
         end
         w.mask[x[3:0]] = 1'b1;
         w.data[int'(x[3:0])*16 +: 16] = pix[k];
      end
      if (open) exp_q.push_back(w);
   endtask

   task automatic apply_stimulus(input int busy_pct, input bit hold_mode, input int cmd_cycles,
                                 input int idx, input int npairs, input bit finished);
      data_valid_i = !finished && ($urandom_range(99) < 75);
      data_pair_i  = (idx < npairs) ? pairs[idx] : $urandom;
      if (hold_mode) gpu_busy_i = (cmd_cycles < 5);
      else           gpu_busy_i = ($urandom_range(99) < busy_pct);
   endtask

   task automatic run_rect(input logic [15:0] x0, input logic [15:0] y0, input int sx, input int sy,
                           input bit index_pattern, input int busy_pct, input bit hold_mode);
      int   npix, npairs, n_exp, idx, writes, cycles, cmd_cycles, budget;
      bit   finished, have_prev;
      wr_t  prev, e;
      npix   = sx * sy;
      npairs = (npix + 1) / 2;
      for (int k = 0; k < npix; k++) pix[k] = index_pattern ? 16'(k) : 16'($urandom);
      for (int i = 0; i < npairs; i++)
         pairs[i] = {((2*i+1) < npix) ? pix[2*i+1] : 16'($urandom), pix[2*i]};
      build_model(x0, y0, sx, npix);
      n_exp = exp_q.size();

      @(posedge clk_i); #1;
      req_x_i = x0; req_y_i = y0; req_sizex_i = 16'(sx); req_sizey_i = 16'(sy);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      check_output("req_accept", req_accept_o, 1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;

      idx = 0; writes = 0; cycles = 0; cmd_cycles = 0; finished = 0; have_prev = 0;
      budget = 40 * npix + 100;
      prev.addr = '0; prev.mask = '0; prev.data = '0;
      apply_stimulus(busy_pct, hold_mode, cmd_cycles, idx, npairs, finished);
      while (!finished && cycles < budget) begin
         @(negedge clk_i);
         cycles++;
         if (gpu_command_o) begin
            cmd_cycles++;
            check_output("accept_in_flush", data_accept_o, 0);
            if (have_prev) begin
               check_output("stall_addr", gpu_addr_o, prev.addr);
               check_output("stall_mask", gpu_write_mask_o, prev.mask);
               check_output("stall_data", gpu_data_out_o, prev.data);
            end
            if (gpu_busy_i) begin
               have_prev = 1;
               prev.addr = gpu_addr_o; prev.mask = gpu_write_mask_o; prev.data = gpu_data_out_o;
            end else begin
               have_prev = 0;
               writes++;
               if (exp_q.size() == 0) begin
                  check_output("extra_write", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_output("write_addr", gpu_addr_o, e.addr);
                  check_output("write_mask", gpu_write_mask_o, e.mask);
                  check_output("write_data", gpu_data_out_o, e.data);
                  check_output("write_cmd", {gpu_write_o, gpu_size_o, gpu_sub_addr_o}, {1'b1, 2'd1, 3'd0});
               end
            end
         end else begin
            have_prev = 0;
         end
         if (data_accept_o) begin
            if (idx >= npairs) check_output("extra_accept", 1, 0);
            idx++;
         end
         if (done_o) finished = 1;
         @(posedge clk_i); #1;
         apply_stimulus(busy_pct, hold_mode, cmd_cycles, idx, npairs, finished);
      end
      data_valid_i = 1'b0;
      gpu_busy_i   = 1'b0;
      check_output("done_seen", finished, 1);
      check_output("accept_count", idx, npairs);
      check_output("write_count", writes, n_exp);
      if (hold_mode) check_output("stall_cmd_cycles", cmd_cycles, 6);
      @(negedge clk_i);
      check_output("done_one_cycle", done_o, 0);
      check_output("idle_after_done", {req_accept_o, busy_o}, 2'b10);
   endtask

   initial begin
      rst_ni = 1'b0; req_valid_i = 1'b0; req_x_i = '0; req_y_i = '0;
      req_sizex_i = '0; req_sizey_i = '0; data_valid_i = 1'b0; data_pair_i = '0; gpu_busy_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_output("rst_req_accept", req_accept_o, 1);
      check_output("rst_flags", {data_accept_o, busy_o, done_o, gpu_command_o}, 4'b0000);
      check_output("rst_mask", gpu_write_mask_o, 0);
      check_output("rst_data", gpu_data_out_o, 0);
      #2 rst_ni = 1'b1;

      $display("[TB] directed rectangles");
      run_rect(16'd0,    16'd0,  16, 1, 1, 0,  0);
      run_rect(16'd5,    16'd3,  4,  2, 0, 0,  0);
      run_rect(16'd14,   16'd0,  3,  1, 0, 0,  0);
      run_rect(16'd1022, 16'd10, 4,  1, 0, 0,  0);
      run_rect(16'd32,   16'd7,  16, 1, 0, 0,  1);

      $display("[TB] randomized rectangles");
      for (int t = 0; t < 24; t++) begin
         logic [15:0] rx, ry;
         rx = $urandom_range(1) ? 16'($urandom_range(1000, 1023)) : 16'($urandom_range(0, 1023));
         ry = 16'($urandom_range(0, 511));
         run_rect(rx, ry, $urandom_range(0, 40), $urandom_range(0, 4), 0, 30, 0);
      end

      $display("[TB] reset during fill");
      @(posedge clk_i); #1;
      req_x_i = 16'd0; req_y_i = 16'd0; req_sizex_i = 16'd16; req_sizey_i = 16'd1;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      data_valid_i = 1'b1; data_pair_i = 32'h1234_5678;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_output("mid_fill_busy", busy_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      check_output("async_rst_req_accept", req_accept_o, 1);
      check_output("async_rst_flags", {data_accept_o, busy_o, done_o, gpu_command_o}, 4'b0000);
      check_output("async_rst_mask", gpu_write_mask_o, 0);
      check_output("async_rst_data", gpu_data_out_o, 0);
      check_output("async_rst_addr", gpu_addr_o, 0);
      data_valid_i = 1'b0;
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      run_rect(16'd7, 16'd3, 0, 5, 0, 0, 0);
      run_rect(16'd7, 16'd3, 9, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
